// File: rtl/l1_icache_if.sv
// Fetch and refill bus for l1_icache: CPU fetch request/response plus the beat-based memory refill port.
// The slave modport is the cache's view; the master modport is the fetch stage / memory side.
interface l1_icache_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              clk_en;
    logic [ADDR_W-1:0] read_addr;
    logic              flush;
    logic [DATA_W-1:0] read_data;
    logic              data_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    modport slave (
        input  clk_en, read_addr, flush, mem_rdata, mem_valid,
        output read_data, data_ready, mem_req, mem_addr
    );

    modport master (
        output clk_en, read_addr, flush, mem_rdata, mem_valid,
        input  read_data, data_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/l1_icache.sv
// Direct-mapped L1 instruction cache with line refill over a beat-based memory port.
// Optional hit/miss performance counters are built when L1_ICACHE_PERF_EN is defined.
module l1_icache #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned OFFSET_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    l1_icache_if.slave  bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W = INDEX_W + OFFSET_W;
    localparam int unsigned LINES  = 1 << INDEX_W;
    localparam int unsigned WORDS  = 1 << LINE_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    if (ADDR_W <= INDEX_W + OFFSET_W) begin : g_bad_params
        $error("l1_icache: tag width must be at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RESPOND} state_t;

    state_t              state;
    logic [DATA_W-1:0]   data_mem [WORDS];
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [LINES-1:0]    valid;
    logic [ADDR_W-1:0]   pend_addr;
    logic [OFFSET_W-1:0] beat;
    logic                flush_pend;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [INDEX_W-1:0]  pend_idx;
    logic [TAG_W-1:0]    pend_tag;
    logic                hit;
    logic                fill_we;

    assign req_tag  = bus.read_addr[ADDR_W-1 -: TAG_W];
    assign req_idx  = bus.read_addr[LINE_W-1 -: INDEX_W];
    assign pend_tag = pend_addr[ADDR_W-1 -: TAG_W];
    assign pend_idx = pend_addr[LINE_W-1 -: INDEX_W];
    assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill_we  = !rst && (state == S_FILL) && bus.mem_valid;

    // Data array has no reset; valid bits gate every read.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{pend_idx, beat}] <= bus.mem_rdata;
        end
    end

`ifdef L1_ICACHE_PERF_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            bus.read_data  <= '0;
            bus.data_ready <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            valid          <= '0;
            beat           <= '0;
            flush_pend     <= 1'b0;
            pend_addr      <= '0;
`ifdef L1_ICACHE_PERF_EN
            hit_q          <= 32'd0;
            miss_q         <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // A flush (live or deferred from a refill) takes the whole cycle.
                    if (flush_pend || bus.flush) begin
                        valid          <= '0;
                        flush_pend     <= 1'b0;
                        bus.data_ready <= 1'b0;
                    end else if (bus.clk_en) begin
                        pend_addr <= bus.read_addr;
                        if (hit) begin
                            bus.read_data  <= data_mem[bus.read_addr[LINE_W-1:0]];
                            bus.data_ready <= 1'b1;
`ifdef L1_ICACHE_PERF_EN
                            hit_q          <= hit_q + 32'd1;
`endif
                        end else begin
                            bus.data_ready <= 1'b0;
                            bus.mem_req    <= 1'b1;
                            bus.mem_addr   <= {req_tag, req_idx, OFFSET_W'(0)};
                            beat           <= '0;
                            state          <= S_FILL;
`ifdef L1_ICACHE_PERF_EN
                            miss_q         <= miss_q + 32'd1;
`endif
                        end
                    end
                end
                S_FILL: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (bus.mem_valid) begin
                        beat <= OFFSET_W'(beat + 1'b1);
                        if (beat == LAST_BEAT) begin
                            bus.mem_req       <= 1'b0;
                            tag_mem[pend_idx] <= pend_tag;
                            valid[pend_idx]   <= 1'b1;
                            state             <= S_RESPOND;
                        end
                    end
                end
                S_RESPOND: begin
                    if (bus.flush) begin
                        flush_pend <= 1'b1;
                    end
                    bus.read_data  <= data_mem[pend_addr[LINE_W-1:0]];
                    bus.data_ready <= 1'b1;
                    state          <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_icache.sv
// Directed self-checking bench for l1_icache: cold/conflict misses, hits, clk_en stalls,
// flushes, wait states, reset mid-fill and the optional performance counters.
module tb_l1_icache;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        mem_hold = 1'b0;
    int          tb_beat = 0;
    int          vectors = 0;
    int          errors = 0;

    l1_icache_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    l1_icache #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4), .OFFSET_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Backing memory: word at line-base b, beat k returns 0xA0 + k + ((b>>2) - 4) * 0x100.
    function automatic logic [31:0] memf(input logic [15:0] a);
        return 32'hA0 + 32'(a[1:0]) + ((32'(a) >> 2) - 32'd4) * 32'h100;
    endfunction

    // Memory responder: one beat per cycle while mem_req is high, unless held.
    always @(negedge clk) begin
        if (bus.mem_req !== 1'b1) begin
            tb_beat       = 0;
            bus.mem_valid = 1'b0;
            bus.mem_rdata = 32'd0;
        end else begin
            if (bus.mem_valid) tb_beat = tb_beat + 1;
            bus.mem_valid = !mem_hold;
            bus.mem_rdata = memf(bus.mem_addr | 16'(tb_beat));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.data_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.data_ready), 32'd1);
    endtask

    task automatic chk_counters(input string tag, input int h, input int m);
`ifdef L1_ICACHE_PERF_EN
        chk({tag, "_hits"}, hit_count, 32'(h));
        chk({tag, "_misses"}, miss_count, 32'(m));
`else
        chk({tag, "_hits"}, hit_count, 32'd0);
        chk({tag, "_misses"}, miss_count, 32'd0);
`endif
    endtask

    initial begin
        bus.clk_en    = 1'b0;
        bus.read_addr = 16'h0;
        bus.flush     = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = 32'd0;

        // Reset
        repeat (3) step();
        chk("rst_read_data", bus.read_data, 32'd0);
        chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk_counters("rst", 0, 0);

        // Cold miss at 0x0012
        rst = 1'b0; bus.clk_en = 1'b1; bus.read_addr = 16'h0012;
        step();
        chk("cold_ready", 32'(bus.data_ready), 32'd0);
        chk("cold_req", 32'(bus.mem_req), 32'd1);
        chk("cold_addr", 32'(bus.mem_addr), 32'h0010);
        repeat (3) step();
        chk("cold_req_edge3", 32'(bus.mem_req), 32'd1);
        step();
        chk("cold_req_edge4", 32'(bus.mem_req), 32'd0);
        chk("cold_ready_edge4", 32'(bus.data_ready), 32'd0);
        step();
        chk("cold_ready_edge5", 32'(bus.data_ready), 32'd1);
        chk("cold_data", bus.read_data, 32'h0000_00A2);

        // Back-to-back hits
        bus.read_addr = 16'h0010; step();
        chk("hit10_ready", 32'(bus.data_ready), 32'd1);
        chk("hit10_data", bus.read_data, 32'h0000_00A0);
        bus.read_addr = 16'h0011; step();
        chk("hit11_data", bus.read_data, 32'h0000_00A1);
        bus.read_addr = 16'h0013; step();
        chk("hit13_data", bus.read_data, 32'h0000_00A3);
        chk("hit13_req", 32'(bus.mem_req), 32'd0);
        chk_counters("cnt_1m3h", 3, 1);

        // Conflict miss on index 4
        bus.read_addr = 16'h0052; step();
        chk("conf52_ready", 32'(bus.data_ready), 32'd0);
        chk("conf52_addr", 32'(bus.mem_addr), 32'h0050);
        wait_ready("conf52_wait");
        chk("conf52_data", bus.read_data, 32'h0000_10A2);
        bus.read_addr = 16'h0012; step();
        chk("conf12_ready", 32'(bus.data_ready), 32'd0);
        chk("conf12_addr", 32'(bus.mem_addr), 32'h0010);
        wait_ready("conf12_wait");
        chk("conf12_data", bus.read_data, 32'h0000_00A2);

        // clk_en stall in IDLE: outputs hold while read_addr wanders
        bus.read_addr = 16'h0011; step();
        chk("pre_stall_data", bus.read_data, 32'h0000_00A1);
        bus.clk_en = 1'b0;
        bus.read_addr = 16'h0010; step();
        bus.read_addr = 16'h0052; step();
        bus.read_addr = 16'h0013; step();
        chk("stall_data", bus.read_data, 32'h0000_00A1);
        chk("stall_ready", 32'(bus.data_ready), 32'd1);
        chk("stall_req", 32'(bus.mem_req), 32'd0);
        bus.clk_en = 1'b1; step();
        chk("post_stall_data", bus.read_data, 32'h0000_00A3);

        // Refill completes on schedule with clk_en low during FILL
        bus.read_addr = 16'h0021; step();
        chk("fill21_addr", 32'(bus.mem_addr), 32'h0020);
        bus.clk_en = 1'b0; bus.read_addr = 16'h0000;
        repeat (4) step();
        chk("fill21_ready_edge4", 32'(bus.data_ready), 32'd0);
        step();
        chk("fill21_ready_edge5", 32'(bus.data_ready), 32'd1);
        chk("fill21_data", bus.read_data, 32'h0000_04A1);

        // Flush in IDLE, then a previously hit address misses
        bus.flush = 1'b1; step();
        chk("flush_ready", 32'(bus.data_ready), 32'd0);
        bus.flush = 1'b0; bus.clk_en = 1'b1; bus.read_addr = 16'h0013; step();
        chk("flush_miss_req", 32'(bus.mem_req), 32'd1);
        chk("flush_miss_addr", 32'(bus.mem_addr), 32'h0010);
        wait_ready("flush_miss_wait");
        chk("flush_miss_data", bus.read_data, 32'h0000_00A3);

        // Flush during FILL with memory wait states
        bus.read_addr = 16'h0052; step();
        chk("ffill_req", 32'(bus.mem_req), 32'd1);
        step();
        bus.flush = 1'b1; mem_hold = 1'b1; step();
        bus.flush = 1'b0; step();
        chk("ffill_wait_req", 32'(bus.mem_req), 32'd1);
        mem_hold = 1'b0;
        wait_ready("ffill_wait");
        chk("ffill_data", bus.read_data, 32'h0000_10A2);
        step();
        step();
        chk("ffill_after_req", 32'(bus.mem_req), 32'd1);
        chk("ffill_after_addr", 32'(bus.mem_addr), 32'h0050);
        wait_ready("ffill_after_wait");
        chk("ffill_after_data", bus.read_data, 32'h0000_10A2);
        chk_counters("cnt_pre_rst", 5, 7);

        // Reset after two of four beats
        bus.read_addr = 16'h0031; step();
        chk("rfill_addr", 32'(bus.mem_addr), 32'h0030);
        repeat (2) step();
        rst = 1'b1; step();
        chk("rfill_req", 32'(bus.mem_req), 32'd0);
        chk("rfill_ready", 32'(bus.data_ready), 32'd0);
        chk("rfill_data", bus.read_data, 32'd0);
        chk_counters("rfill_cnt", 0, 0);
        rst = 1'b0; step();
        chk("rfill_remiss_req", 32'(bus.mem_req), 32'd1);
        chk("rfill_remiss_addr", 32'(bus.mem_addr), 32'h0030);
        chk_counters("rfill_remiss_cnt", 0, 1);
        wait_ready("rfill_remiss_wait");
        chk("rfill_remiss_data", bus.read_data, 32'h0000_08A1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "simulation timeout");
    end
endmodule

// File: doc/l1_icache.md
# l1_icache

Parametrised direct-mapped L1 instruction cache between the fetch stage and the backing instruction memory. Replaces the fixed 64-word preloaded store with a tagged, valid-bit cache. Misses are refilled one line at a time over a simple beat-based memory port, and `data_ready` drops while a refill is in progress. All addresses are word addresses.

## Interface
- `ADDR_W`, 16, word-address width on both CPU and memory sides.
- `DATA_W`, 32, instruction word width.
- `INDEX_W`, 4, line-index bits; the cache has 2^INDEX_W lines.
- `OFFSET_W`, 2, word-in-line bits; each line holds 2^OFFSET_W words.
- Tag width is ADDR_W-INDEX_W-OFFSET_W and must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  CPU-side enable; qualifies request acceptance only.
- `read_addr`  in  ADDR_W  fetch word address.
- `flush`  in  1  invalidate all lines.
- `read_data`  out  DATA_W  instruction for the last accepted address.
- `data_ready`  out  1  `read_data` is valid for the last accepted address.
- `mem_req`  out  1  refill request, held high for the whole refill.
- `mem_addr`  out  ADDR_W  line base address: {tag, index, OFFSET_W'b0}.
- `mem_rdata`  in  DATA_W  refill beat data.
- `mem_valid`  in  1  refill beat strobe; beats arrive in ascending word order.
- `hit_count`  out  32  hit counter (see Configuration).
- `miss_count`  out  32  miss counter (see Configuration).

## Operation
- **Address split:** tag = read_addr[ADDR_W-1:INDEX_W+OFFSET_W], index = next INDEX_W bits, offset = low OFFSET_W bits.
- **Storage:** data array of 2^(INDEX_W+OFFSET_W) words, a tag array and a valid bit per line.
- **State IDLE:**
  - With clk_en=1, read_addr is accepted every cycle and latched as the pending address.
  - Hit (valid and tag equal): read_data ← word, data_ready ← 1, stay in IDLE.
  - Miss: data_ready ← 0, mem_addr ← line base, mem_req ← 1, beat counter ← 0, go to FILL.
  - With clk_en=0, nothing is accepted and all outputs hold.
- **State FILL:**
  - Each mem_valid writes mem_rdata into word [index, beat] and increments the beat counter.
  - On the last beat (beat = 2^OFFSET_W-1): mem_req ← 0, the line tag is written, valid ← 1, go to RESPOND.
  - clk_en and read_addr are ignored in FILL.
- **State RESPOND:** read_data ← the pending word from the array, data_ready ← 1, go to IDLE. This happens regardless of clk_en.
- **mem_valid** is ignored outside FILL.
- **Flush:**
  - In IDLE, flush clears all valid bits that edge and suppresses acceptance that cycle; data_ready ← 0.
  - In FILL or RESPOND, flush is latched and applied on the first IDLE cycle, after RESPOND has delivered the word. The refilled line is therefore invalidated.
- **Reset** (synchronous, overrides everything including mid-fill):
  - read_data=0, data_ready=0, mem_req=0, mem_addr=0, state IDLE.
  - All valid bits and the beat counter are 0, pending flush is 0, and both counters are 0.
  - A refill aborted by reset is abandoned. The memory side must drop any outstanding beats when mem_req falls.

## Timing
- **Hit latency:** 1 cycle. read_data and data_ready are updated on the accepting edge.
- **Back-to-back hits:** sustained one per cycle while clk_en=1.
- **Miss:** data_ready is 0 from the accepting edge.
  - mem_req rises on the accepting edge and falls on the last-beat edge.
  - data_ready returns to 1 one edge after the last beat.
  - With mem_valid high every FILL cycle, data_ready=1 at the 2^OFFSET_W+1 edge after acceptance (5 for defaults).
- **Wait states:** mem_valid gaps stall FILL indefinitely. There is no timeout.
- **CPU contract:** the CPU must treat data_ready=0 as a fetch stall and must not expect any request to be accepted until data_ready=1.

## Configuration
- `L1_ICACHE_PERF_EN` defined:
  - hit_count increments on each accepted hit.
  - miss_count increments on each accepted miss.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst. flush does not clear them.
- Undefined: hit_count and miss_count are constant 0 and no counter registers are built.

## Test plan
- **Reset:** reset, then read 0x0012 → data_ready=0, mem_req=1, mem_addr=0x0010. All outputs were 0 during rst.
- **Cold miss:** cold miss at 0x0012 with memory returning 0xA0+beat on consecutive beats → data_ready=1 and read_data=0xA2 exactly 5 edges after acceptance. Then 0x0010, 0x0011, 0x0013 hit back-to-back with 0xA0, 0xA1, 0xA3.
- **Conflict miss:** 0x0052 after the 0x0012 line is filled (same index 4, tag 1) → miss, mem_addr=0x0050. A following 0x0012 misses again.
- **clk_en stall:** clk_en=0 for 3 cycles mid-stream while read_addr changes → read_data and data_ready hold. A refill already in FILL completes on schedule.
- **Flush:**
  - flush in IDLE → next read of a previously hit address misses.
  - flush asserted during FILL → the pending word is still delivered, then the line reads as a miss.
- **Reset mid-fill and counters:**
  - rst after 2 of 4 beats → mem_req=0 and data_ready=0 next cycle, and the line is invalid.
  - With L1_ICACHE_PERF_EN, the sequence 1 miss + 3 hits gives hit_count=3, miss_count=1.
